fifo_rd_packer: RTL and testbench

Read-side drain stage sitting directly downstream of the synchronous FIFO. It pops FIFO_WIDTH-bit words using the FIFO's `rd_en`/`data_out`/`empty` interface, which has one cycle of read latency. It packs PACK consecutive words into one wide beat and presents that beat on a valid/ready stream to the next stage. A flush request emits a partially filled beat with a lane-keep mask.

---
 rtl/fifo_rd_packer.sv | 128 ++++++++++++
 tb/tb_fifo_rd_packer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_rd_packer                                                             |
// | Drains a 1-cycle-latency FIFO and packs PACK words into one valid/ready    |
// | beat. A flush emits a partial beat with a lane-keep mask.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fifo_rd_packer #(
    parameter int FIFO_WIDTH = 16,
    parameter int PACK       = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fifo_empty,
    input  logic                       fifo_underflow,
    input  logic [FIFO_WIDTH-1:0]      fifo_data_out,
    output logic                       fifo_rd_en,
    input  logic                       flush,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [FIFO_WIDTH*PACK-1:0] m_data,
    output logic [PACK-1:0]            m_keep,
    output logic                       err
);

    localparam int c_fill_w = $clog2(PACK + 1);
    localparam logic [c_fill_w-1:0] c_full = c_fill_w'(PACK);
    localparam logic [c_fill_w:0]   c_pack_ext = (c_fill_w + 1)'(PACK);

    logic [PACK-1:0][FIFO_WIDTH-1:0] r_pack;
    logic [c_fill_w-1:0]             r_fill;
    logic                            r_rd_pending;
    logic                            r_flush_req;
    logic [FIFO_WIDTH*PACK-1:0]      r_m_data;
    logic [PACK-1:0]                 r_m_keep;
    logic                            r_m_valid;
    logic                            r_err;

    logic                            w_full;
    logic                            w_flush_part;
    logic                            w_out_free;
    logic                            w_xfer;
    logic                            w_idle;
    logic [c_fill_w:0]               w_occ;
    logic                            w_rd_en;
    logic [c_fill_w-1:0]             w_base;
    logic [c_fill_w-1:0]             w_fill_nxt;
    logic [PACK-1:0][FIFO_WIDTH-1:0] w_beat;
    logic [PACK-1:0]                 w_keep;

    assign w_full       = (r_fill == c_full);
    assign w_flush_part = r_flush_req && !r_rd_pending && (r_fill != '0);
    assign w_out_free   = !r_m_valid || m_ready;
    assign w_xfer       = (w_full || w_flush_part) && w_out_free;
    assign w_idle       = (r_fill == '0) && !r_rd_pending;

    // Words already held plus the one still in flight must leave room for a new pop.
    assign w_occ   = {1'b0, r_fill} + (c_fill_w + 1)'(r_rd_pending);
    assign w_rd_en = rst_n && !fifo_empty && !r_flush_req && ((w_occ < c_pack_ext) || w_xfer);

    // A word landing during a transfer starts the next beat in lane 0.
    assign w_base     = w_xfer ? '0 : r_fill;
    assign w_fill_nxt = w_base + c_fill_w'(r_rd_pending);

    generate
        for (genvar g = 0; g < PACK; g++) begin : g_lane
            assign w_keep[g] = (c_fill_w'(g) < r_fill);
            assign w_beat[g] = w_keep[g] ? r_pack[g] : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pack       <= '0;
            r_fill       <= '0;
            r_rd_pending <= 1'b0;
            r_flush_req  <= 1'b0;
            r_m_data     <= '0;
            r_m_keep     <= '0;
            r_m_valid    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_rd_pending <= w_rd_en;

            if (r_rd_pending) begin
                for (int i = 0; i < PACK; i++) begin
                    if (w_base == c_fill_w'(i)) begin
                        r_pack[i] <= fifo_data_out;
                    end
                end
            end

            if (r_rd_pending || w_xfer) begin
                r_fill <= w_fill_nxt;
            end

            if (w_xfer) begin
                r_m_data  <= w_beat;
                r_m_keep  <= w_keep;
                r_m_valid <= 1'b1;
            end else if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end

            // A full beat pending under flush leaves normally; the request then
            // retires either on the partial beat or once nothing is left.
            if (r_flush_req) begin
                if (w_flush_part && w_out_free || w_idle) begin
                    r_flush_req <= 1'b0;
                end
            end else if (flush) begin
                r_flush_req <= 1'b1;
            end

            if (fifo_underflow || (r_rd_pending && w_full && !w_xfer)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign m_valid    = r_m_valid;
    assign m_data     = r_m_data;
    assign m_keep     = r_m_keep;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fifo_rd_packer                                                          |
// | Self-checking bench: behavioural FIFO, beat scoreboard, cycle vectors.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fifo_rd_packer;

    localparam int FIFO_WIDTH = 16;
    localparam int PACK       = 2;

    logic                       clk;
    logic                       rst_n;
    logic                       fifo_empty;
    logic                       fifo_underflow;
    logic [FIFO_WIDTH-1:0]      fifo_data_out;
    logic                       fifo_rd_en;
    logic                       flush;
    logic                       m_valid;
    logic                       m_ready;
    logic [FIFO_WIDTH*PACK-1:0] m_data;
    logic [PACK-1:0]            m_keep;
    logic                       err;

    fifo_rd_packer #(
        .FIFO_WIDTH (FIFO_WIDTH),
        .PACK       (PACK)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_data_out  (fifo_data_out),
        .fifo_rd_en     (fifo_rd_en),
        .flush          (flush),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_keep         (m_keep),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  keep;
    } beat_t;

    typedef struct {
        logic ready;
        logic exp_rd;
        logic exp_valid;
    } vec_t;

    logic [FIFO_WIDTH-1:0] fq[$];
    beat_t                 exp_q[$];
    vec_t                  tbl[9];

    int   total;
    int   bad;
    int   n_pops;
    logic s_rd_en;
    logic s_valid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [FIFO_WIDTH-1:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic [1:0] k);
        beat_t b;
        b.data = d;
        b.keep = k;
        exp_q.push_back(b);
    endtask

    // One clock: sample before the edge, model the FIFO pop and score accepted beats after it.
    task automatic step();
        logic        acc;
        logic [31:0] d;
        logic [1:0]  k;
        beat_t       b;
        #1;
        s_rd_en = fifo_rd_en;
        s_valid = m_valid;
        acc     = m_valid && m_ready;
        d       = m_data;
        k       = m_keep;
        @(posedge clk);
        #1;
        if (s_rd_en) begin
            n_pops++;
            if (fq.size() > 0) fifo_data_out = fq.pop_front();
        end
        fifo_empty = (fq.size() == 0);
        if (acc) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got beat %0h keep %0b expected none", d, k);
            end else begin
                b = exp_q.pop_front();
                chk("sb_data", 64'(d), 64'(b.data));
                chk("sb_keep", 64'(k), 64'(b.keep));
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        n_pops = 0;

        // Steady-state PACK=2 vectors: rd_en 1,1,0,1,1 then idle; beats visible in cycles 4 and 7.
        tbl[0] = '{1'b1, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b1};
        tbl[8] = '{1'b1, 1'b0, 1'b0};

        rst_n          = 1'b0;
        fifo_empty     = 1'b1;
        fifo_underflow = 1'b0;
        fifo_data_out  = '0;
        flush          = 1'b0;
        m_ready        = 1'b0;

        // Reset state
        steps(2);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data",  64'(m_data),  64'd0);
        chk("rst_m_keep",  64'(m_keep),  64'd0);
        chk("rst_err",     64'(err),     64'd0);
        fifo_empty = 1'b0;
        #1;
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        fifo_empty = 1'b1;
        rst_n = 1'b1;
        step();
        n_pops = 0;

        // Basic packing from a preloaded FIFO
        for (int i = 1; i <= 4; i++) push_word(16'(i));
        expect_beat(32'h0002_0001, 2'b11);
        expect_beat(32'h0004_0003, 2'b11);
        for (int i = 0; i < 9; i++) begin
            m_ready = tbl[i].ready;
            step();
            chk($sformatf("vec%0d_rd_en", i), 64'(s_rd_en), 64'(tbl[i].exp_rd));
            chk($sformatf("vec%0d_valid", i), 64'(s_valid), 64'(tbl[i].exp_valid));
        end

        // Backpressure: 6 words queued, output stalled for 10 cycles
        m_ready = 1'b0;
        n_pops  = 0;
        for (int i = 0; i < 6; i++) push_word(16'h0010 + 16'(i));
        expect_beat(32'h0011_0010, 2'b11);
        expect_beat(32'h0013_0012, 2'b11);
        expect_beat(32'h0015_0014, 2'b11);
        steps(10);
        chk("bp_pops",    64'(n_pops),  64'd4);
        chk("bp_valid",   64'(m_valid), 64'd1);
        chk("bp_data",    64'(m_data),  64'h0011_0010);
        chk("bp_keep",    64'(m_keep),  64'h3);
        chk("bp_err",     64'(err),     64'd0);
        m_ready = 1'b1;
        steps(12);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // Flush one cycle after a lone word is popped
        push_word(16'hABCD);
        expect_beat(32'h0000_ABCD, 2'b01);
        step();
        chk("fl_pop", 64'(s_rd_en), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        push_word(16'h5555);
        push_word(16'h5556);
        expect_beat(32'h5556_5555, 2'b11);
        step();
        chk("fl_hold_rd", 64'(s_rd_en), 64'd0);
        step();
        chk("fl_resume_rd", 64'(s_rd_en), 64'd1);
        steps(6);
        chk("fl_drained", 64'(exp_q.size()), 64'd0);

        // Flush with nothing packed
        flush = 1'b1;
        step();
        flush = 1'b0;
        push_word(16'h0101);
        push_word(16'h0202);
        expect_beat(32'h0202_0101, 2'b11);
        step();
        chk("fe_block_rd", 64'(s_rd_en), 64'd0);
        chk("fe_no_beat",  64'(s_valid), 64'd0);
        step();
        chk("fe_resume_rd", 64'(s_rd_en), 64'd1);
        steps(6);
        chk("fe_drained", 64'(exp_q.size()), 64'd0);

        // Reset mid-operation with one word packed and a beat held
        m_ready = 1'b0;
        push_word(16'h0021);
        push_word(16'h0022);
        push_word(16'h0023);
        steps(5);
        chk("mr_pre_valid", 64'(m_valid), 64'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mr_valid", 64'(m_valid), 64'd0);
        chk("mr_keep",  64'(m_keep),  64'd0);
        chk("mr_data",  64'(m_data),  64'd0);
        m_ready = 1'b1;
        push_word(16'h0031);
        push_word(16'h0032);
        expect_beat(32'h0032_0031, 2'b11);
        steps(7);
        chk("mr_drained", 64'(exp_q.size()), 64'd0);

        // Sticky underflow error
        chk("uf_pre_err", 64'(err), 64'd0);
        fifo_underflow = 1'b1;
        step();
        fifo_underflow = 1'b0;
        chk("uf_err", 64'(err), 64'd1);
        steps(3);
        chk("uf_err_held", 64'(err), 64'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("uf_err_rst", 64'(err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
